// File: rtl/chimera_pkg.sv
// Shared types and default timing constants for the Chimera cluster power sequencer.
`timescale 1ns/1ps
package chimera_pkg;

    localparam int unsigned ChimeraClkSettleCycles  = 4;
    localparam int unsigned ChimeraRstHoldCycles    = 8;
    localparam int unsigned ChimeraIsoTimeoutCycles = 256;

    typedef enum logic [2:0] {
        CluPwrOff    = 3'd0,
        CluPwrClkOn  = 3'd1,
        CluPwrRstRel = 3'd2,
        CluPwrDeiso  = 3'd3,
        CluPwrOn     = 3'd4,
        CluPwrIso    = 3'd5,
        CluPwrRstAsr = 3'd6,
        CluPwrErr    = 3'd7
    } clu_pwr_state_e;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/chimera_clu_pwr_fsm.sv
// One cluster's power/isolation sequencer: state, dwell counter, sticky error (and irq).
// Optional irq output/clear enabled by `CHIMERA_CLU_PWR_IRQ_EN.
`timescale 1ns/1ps
module chimera_clu_pwr_fsm
    import chimera_pkg::*;
#(
    parameter int unsigned ClkSettleCycles  = ChimeraClkSettleCycles,
    parameter int unsigned RstHoldCycles    = ChimeraRstHoldCycles,
    parameter int unsigned IsoTimeoutCycles = ChimeraIsoTimeoutCycles
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic isolated_i,
    input  logic err_clr_i,
`ifdef CHIMERA_CLU_PWR_IRQ_EN
    input  logic irq_clr_i,
    output logic irq_o,
`endif
    output logic isolate_o,
    output logic clk_en_o,
    output logic rst_no,
    output logic on_o,
    output logic busy_o,
    output logic err_o
);

    localparam int unsigned MaxCycles = max3(ClkSettleCycles, RstHoldCycles, IsoTimeoutCycles);
    localparam int unsigned CntWidth  = $clog2(MaxCycles + 1);

    localparam logic [CntWidth-1:0] ClkLoad = CntWidth'(ClkSettleCycles - 1);
    localparam logic [CntWidth-1:0] RstLoad = CntWidth'(RstHoldCycles - 1);
    localparam logic [CntWidth-1:0] IsoLoad = CntWidth'(IsoTimeoutCycles - 1);

    clu_pwr_state_e      state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                isolate_q, isolate_d;
    logic                clk_en_q, clk_en_d;
    logic                rst_n_q, rst_n_d;
    logic                on_q, on_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;
    logic                timeout;
    logic                cnt_zero;
`ifdef CHIMERA_CLU_PWR_IRQ_EN
    logic                irq_q, irq_d;
`endif

    assign cnt_zero = (cnt_q == '0);

    // Next state, dwell counter reload and next registered outputs
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_zero ? cnt_q : cnt_q - CntWidth'(1);
        timeout = 1'b0;

        case (state_q)
            CluPwrOff:    if (en_i) state_d = CluPwrClkOn;
            CluPwrClkOn:  if (cnt_zero) state_d = CluPwrRstRel;
            CluPwrRstRel: if (cnt_zero) state_d = CluPwrDeiso;
            CluPwrDeiso: begin
                if (!isolated_i) begin
                    state_d = CluPwrOn;
                end else if (cnt_zero) begin
                    state_d = CluPwrIso;
                    timeout = 1'b1;
                end
            end
            CluPwrOn:     if (!en_i) state_d = CluPwrIso;
            CluPwrIso: begin
                if (isolated_i) begin
                    state_d = CluPwrRstAsr;
                end else if (cnt_zero) begin
                    state_d = CluPwrErr;
                    timeout = 1'b1;
                end
            end
            CluPwrRstAsr: if (cnt_zero) state_d = CluPwrOff;
            CluPwrErr:    if (err_clr_i) state_d = CluPwrRstAsr;
            default:      state_d = CluPwrOff;
        endcase

        if (state_d != state_q) begin
            case (state_d)
                CluPwrClkOn, CluPwrRstAsr: cnt_d = ClkLoad;
                CluPwrRstRel:              cnt_d = RstLoad;
                CluPwrDeiso, CluPwrIso:    cnt_d = IsoLoad;
                default:                   cnt_d = '0;
            endcase
        end

        isolate_d = !(state_d inside {CluPwrDeiso, CluPwrOn});
        clk_en_d  = (state_d != CluPwrOff);
        rst_n_d   = state_d inside {CluPwrRstRel, CluPwrDeiso, CluPwrOn, CluPwrIso, CluPwrErr};
        on_d      = (state_d == CluPwrOn);
        busy_d    = !(state_d inside {CluPwrOff, CluPwrOn});

        // A timeout in the same cycle beats a clear
        err_d = timeout ? 1'b1 : (err_clr_i ? 1'b0 : err_q);
`ifdef CHIMERA_CLU_PWR_IRQ_EN
        irq_d = ((state_d != state_q) && (state_d inside {CluPwrOn, CluPwrOff, CluPwrErr}))
                ? 1'b1 : (irq_clr_i ? 1'b0 : irq_q);
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= CluPwrOff;
            cnt_q     <= '0;
            isolate_q <= 1'b1;
            clk_en_q  <= 1'b0;
            rst_n_q   <= 1'b0;
            on_q      <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef CHIMERA_CLU_PWR_IRQ_EN
            irq_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            isolate_q <= isolate_d;
            clk_en_q  <= clk_en_d;
            rst_n_q   <= rst_n_d;
            on_q      <= on_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
`ifdef CHIMERA_CLU_PWR_IRQ_EN
            irq_q     <= irq_d;
`endif
        end
    end

    assign isolate_o = isolate_q;
    assign clk_en_o  = clk_en_q;
    assign rst_no    = rst_n_q;
    assign on_o      = on_q;
    assign busy_o    = busy_q;
    assign err_o     = err_q;
`ifdef CHIMERA_CLU_PWR_IRQ_EN
    assign irq_o     = irq_q;
`endif

endmodule

// File: rtl/chimera_clu_pwr_seq.sv
// Per-cluster power/isolation sequencer array: one independent FSM per external cluster.
// Optional irq_o/irq_clr_i ports enabled by `CHIMERA_CLU_PWR_IRQ_EN.
`timescale 1ns/1ps
module chimera_clu_pwr_seq
    import chimera_pkg::*;
#(
    parameter int unsigned NumClusters      = 5,
    parameter int unsigned ClkSettleCycles  = ChimeraClkSettleCycles,
    parameter int unsigned RstHoldCycles    = ChimeraRstHoldCycles,
    parameter int unsigned IsoTimeoutCycles = ChimeraIsoTimeoutCycles
) (
    input  logic                   soc_clk_i,
    input  logic                   rst_i,
    input  logic [NumClusters-1:0] clu_en_i,
    input  logic [NumClusters-1:0] isolated_i,
    input  logic [NumClusters-1:0] err_clr_i,
`ifdef CHIMERA_CLU_PWR_IRQ_EN
    input  logic [NumClusters-1:0] irq_clr_i,
    output logic [NumClusters-1:0] irq_o,
`endif
    output logic [NumClusters-1:0] isolate_o,
    output logic [NumClusters-1:0] clk_en_o,
    output logic [NumClusters-1:0] clu_rst_no,
    output logic [NumClusters-1:0] on_o,
    output logic [NumClusters-1:0] busy_o,
    output logic [NumClusters-1:0] err_o
);

    for (genvar c = 0; c < NumClusters; c++) begin : gen_clu
        chimera_clu_pwr_fsm #(
            .ClkSettleCycles  (ClkSettleCycles),
            .RstHoldCycles    (RstHoldCycles),
            .IsoTimeoutCycles (IsoTimeoutCycles)
        ) u_fsm (
            .clk_i      (soc_clk_i),
            .rst_i      (rst_i),
            .en_i       (clu_en_i[c]),
            .isolated_i (isolated_i[c]),
            .err_clr_i  (err_clr_i[c]),
`ifdef CHIMERA_CLU_PWR_IRQ_EN
            .irq_clr_i  (irq_clr_i[c]),
            .irq_o      (irq_o[c]),
`endif
            .isolate_o  (isolate_o[c]),
            .clk_en_o   (clk_en_o[c]),
            .rst_no     (clu_rst_no[c]),
            .on_o       (on_o[c]),
            .busy_o     (busy_o[c]),
            .err_o      (err_o[c])
        );
    end

endmodule

// File: tb/tb_chimera_clu_pwr_seq.sv
// Bench for chimera_clu_pwr_seq: directed scenarios plus randomized traffic against a phase/elapsed-time model.
`timescale 1ns/1ps
module tb_chimera_clu_pwr_seq;

    localparam int N          = 5;
    localparam int CLK_SETTLE = 4;
    localparam int RST_HOLD   = 8;
    localparam int ISO_TO     = 16;
`ifdef CHIMERA_CLU_PWR_IRQ_EN
    localparam int VW = 7 * N;
`else
    localparam int VW = 6 * N;
`endif
    localparam logic [VW-1:0] RST_VEC = {{N{1'b1}}, {(VW-N){1'b0}}};

    // Phase numbering is the bench's own; output tables indexed by phase
    localparam int P_OFF = 0, P_CLK = 1, P_RREL = 2, P_DEISO = 3;
    localparam int P_ON  = 4, P_ISO = 5, P_RASR = 6, P_ERR  = 7;
    localparam logic [7:0] ISO_TAB  = 8'b1110_0111;
    localparam logic [7:0] CLK_TAB  = 8'b1111_1110;
    localparam logic [7:0] RSTN_TAB = 8'b1011_1100;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] clu_en, isolated, err_clr;
    logic [N-1:0] isolate_o, clk_en_o, clu_rst_no, on_o, busy_o, err_o;
`ifdef CHIMERA_CLU_PWR_IRQ_EN
    logic [N-1:0] irq_clr, irq_o;
    bit           m_irq [N];
`endif

    int  m_ph [N];
    int  m_t  [N];
    bit  m_err[N];
    int  delay[N];
    int  dcnt [N];
    int  stuck[N];
    int  vec  = 0;
    int  miss = 0;
    int  cyc  = 0;

    chimera_clu_pwr_seq #(
        .NumClusters      (N),
        .ClkSettleCycles  (CLK_SETTLE),
        .RstHoldCycles    (RST_HOLD),
        .IsoTimeoutCycles (ISO_TO)
    ) dut (
        .soc_clk_i  (clk),
        .rst_i      (rst),
        .clu_en_i   (clu_en),
        .isolated_i (isolated),
        .err_clr_i  (err_clr),
`ifdef CHIMERA_CLU_PWR_IRQ_EN
        .irq_clr_i  (irq_clr),
        .irq_o      (irq_o),
`endif
        .isolate_o  (isolate_o),
        .clk_en_o   (clk_en_o),
        .clu_rst_no (clu_rst_no),
        .on_o       (on_o),
        .busy_o     (busy_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    // Advance the model by one edge using the inputs the DUT sampled
    task automatic model_edge();
        for (int c = 0; c < N; c++) begin
            int nph;
            bit to;
            nph = m_ph[c];
            to  = 1'b0;
            if (rst) begin
                m_ph[c] = P_OFF; m_t[c] = 0; m_err[c] = 1'b0;
`ifdef CHIMERA_CLU_PWR_IRQ_EN
                m_irq[c] = 1'b0;
`endif
            end else begin
                case (m_ph[c])
                    P_OFF:   if (clu_en[c]) nph = P_CLK;
                    P_CLK:   if (m_t[c] + 1 >= CLK_SETTLE) nph = P_RREL;
                    P_RREL:  if (m_t[c] + 1 >= RST_HOLD) nph = P_DEISO;
                    P_DEISO: if (!isolated[c]) nph = P_ON;
                             else if (m_t[c] + 1 >= ISO_TO) begin nph = P_ISO; to = 1'b1; end
                    P_ON:    if (!clu_en[c]) nph = P_ISO;
                    P_ISO:   if (isolated[c]) nph = P_RASR;
                             else if (m_t[c] + 1 >= ISO_TO) begin nph = P_ERR; to = 1'b1; end
                    P_RASR:  if (m_t[c] + 1 >= CLK_SETTLE) nph = P_OFF;
                    P_ERR:   if (err_clr[c]) nph = P_RASR;
                    default: nph = P_OFF;
                endcase
                if (to) m_err[c] = 1'b1;
                else if (err_clr[c]) m_err[c] = 1'b0;
`ifdef CHIMERA_CLU_PWR_IRQ_EN
                if (nph != m_ph[c] && (nph == P_ON || nph == P_OFF || nph == P_ERR)) m_irq[c] = 1'b1;
                else if (irq_clr[c]) m_irq[c] = 1'b0;
`endif
                m_t[c]  = (nph != m_ph[c]) ? 0 : m_t[c] + 1;
                m_ph[c] = nph;
            end
        end
    endtask

    // Cluster domain: follows the isolation request after delay[c] cycles unless stuck
    task automatic domain_update();
        for (int c = 0; c < N; c++) begin
            logic want;
            want = ISO_TAB[3'(m_ph[c])];
            if (stuck[c] == 1) isolated[c] = 1'b0;
            else if (stuck[c] == 2) isolated[c] = 1'b1;
            else if (isolated[c] != want) begin
                if (dcnt[c] >= delay[c]) begin isolated[c] = want; dcnt[c] = 0; end
                else dcnt[c]++;
            end else dcnt[c] = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        domain_update();
        cyc++;
    endtask

    function automatic logic [VW-1:0] exp_vec();
        logic [N-1:0] i, k, r, o, b, e;
        for (int c = 0; c < N; c++) begin
            i[c] = ISO_TAB[3'(m_ph[c])];
            k[c] = CLK_TAB[3'(m_ph[c])];
            r[c] = RSTN_TAB[3'(m_ph[c])];
            o[c] = (m_ph[c] == P_ON);
            b[c] = !(m_ph[c] == P_OFF || m_ph[c] == P_ON);
            e[c] = m_err[c];
        end
`ifdef CHIMERA_CLU_PWR_IRQ_EN
        begin
            logic [N-1:0] q;
            for (int c = 0; c < N; c++) q[c] = m_irq[c];
            return {i, k, r, o, b, e, q};
        end
`else
        return {i, k, r, o, b, e};
`endif
    endfunction

    function automatic logic [VW-1:0] dut_vec();
`ifdef CHIMERA_CLU_PWR_IRQ_EN
        return {isolate_o, clk_en_o, clu_rst_no, on_o, busy_o, err_o, irq_o};
`else
        return {isolate_o, clk_en_o, clu_rst_no, on_o, busy_o, err_o};
`endif
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        for (int k = 0; k < 50; k++) begin
            step();
            vec++; if (dut_vec() !== RST_VEC) begin miss++;
                $display("FAIL reset_hold cyc=%0d got=%h exp=%h", cyc, dut_vec(), RST_VEC); end
            vec++; if (dut_vec() !== exp_vec()) begin miss++;
                $display("FAIL reset_model cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec()); end
        end
    endtask

    task automatic test_power_up();
        delay[0] = 2;
        clu_en[0] = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            step();
            vec++; if ({isolate_o[0], clk_en_o[0], clu_rst_no[0], on_o[0]} !==
                       {1'(k < 13), 1'b1, 1'(k >= 5), 1'(k >= 16)}) begin miss++;
                $display("FAIL pwr_up k=%0d got iso/clk/rstn/on=%b%b%b%b", k,
                         isolate_o[0], clk_en_o[0], clu_rst_no[0], on_o[0]); end
            vec++; if ({isolate_o[N-1:1], clk_en_o[N-1:1], clu_rst_no[N-1:1], on_o[N-1:1]} !==
                       {{(N-1){1'b1}}, {(3*(N-1)){1'b0}}}) begin miss++;
                $display("FAIL pwr_up_others k=%0d iso=%b clk=%b", k, isolate_o, clk_en_o); end
            vec++; if (dut_vec() !== exp_vec()) begin miss++;
                $display("FAIL pwr_up_model k=%0d got=%h exp=%h", k, dut_vec(), exp_vec()); end
        end
    endtask

    task automatic test_power_down();
        int n;
        delay[2] = 3;
        clu_en[2] = 1'b1;
        n = 0;
        while (m_ph[2] != P_ON && n < 60) begin
            step(); n++;
            vec++; if (dut_vec() !== exp_vec()) begin miss++;
                $display("FAIL pwr_dn_up cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec()); end
        end
        vec++; if (on_o[2] !== 1'b1) begin miss++;
            $display("FAIL pwr_dn_reach_on got=%b exp=1", on_o[2]); end
        clu_en[2] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            vec++; if ({clu_rst_no[2], clk_en_o[2], busy_o[2], isolate_o[2]} !==
                       {1'(k < 5), 1'(k < 9), 1'(k < 9), 1'b1}) begin miss++;
                $display("FAIL pwr_dn k=%0d got rstn/clk/busy/iso=%b%b%b%b", k,
                         clu_rst_no[2], clk_en_o[2], busy_o[2], isolate_o[2]); end
            vec++; if (dut_vec() !== exp_vec()) begin miss++;
                $display("FAIL pwr_dn_model k=%0d got=%h exp=%h", k, dut_vec(), exp_vec()); end
        end
    endtask

    task automatic test_iso_timeout();
        int n;
        delay[1] = 1;
        clu_en[1] = 1'b1;
        n = 0;
        while (m_ph[1] != P_ON && n < 60) begin
            step(); n++;
            vec++; if (dut_vec() !== exp_vec()) begin miss++;
                $display("FAIL err_up cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec()); end
        end
        stuck[1] = 1;
        clu_en[1] = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            vec++; if ({err_o[1], isolate_o[1], on_o[1], busy_o[1]} !== {1'(k >= 17), 1'b1, 1'b0, 1'b1}) begin miss++;
                $display("FAIL iso_timeout k=%0d got err/iso/on/busy=%b%b%b%b", k,
                         err_o[1], isolate_o[1], on_o[1], busy_o[1]); end
            vec++; if (dut_vec() !== exp_vec()) begin miss++;
                $display("FAIL iso_timeout_model k=%0d got=%h exp=%h", k, dut_vec(), exp_vec()); end
        end
        err_clr[1] = 1'b1;
        step();
        err_clr[1] = 1'b0;
        vec++; if ({err_o[1], clu_rst_no[1], isolate_o[1]} !== 3'b001) begin miss++;
            $display("FAIL err_clear got err/rstn/iso=%b%b%b exp=001", err_o[1], clu_rst_no[1], isolate_o[1]); end
        for (int j = 1; j <= 6; j++) begin
            step();
            vec++; if ({clk_en_o[1], busy_o[1], isolate_o[1]} !== {1'(j < 4), 1'(j < 4), 1'b1}) begin miss++;
                $display("FAIL err_to_off j=%0d got clk/busy/iso=%b%b%b", j, clk_en_o[1], busy_o[1], isolate_o[1]); end
            vec++; if (dut_vec() !== exp_vec()) begin miss++;
                $display("FAIL err_to_off_model j=%0d got=%h exp=%h", j, dut_vec(), exp_vec()); end
        end
        stuck[1] = 0;
    endtask

    task automatic test_toggle();
        delay[3] = 0;
        clu_en[3] = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            step();
            if (k <= 3) clu_en[3] = (k == 2);
            vec++; if ({on_o[3], busy_o[3], clk_en_o[3]} !==
                       {1'(k == 14), 1'(k != 14 && k < 20), 1'(k < 20)}) begin miss++;
                $display("FAIL toggle k=%0d got on/busy/clk=%b%b%b", k, on_o[3], busy_o[3], clk_en_o[3]); end
            vec++; if (dut_vec() !== exp_vec()) begin miss++;
                $display("FAIL toggle_model k=%0d got=%h exp=%h", k, dut_vec(), exp_vec()); end
        end
    endtask

    task automatic test_rst_mid();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        for (int c = 0; c < N; c++) delay[c] = c;
        clu_en = '1;
        repeat (7) begin
            step();
            vec++; if (dut_vec() !== exp_vec()) begin miss++;
                $display("FAIL rst_mid_seq cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec()); end
        end
        vec++; if ({clu_rst_no, isolate_o, busy_o} !== {3*N{1'b1}}) begin miss++;
            $display("FAIL rst_mid_in_rst_rel got rstn=%b iso=%b busy=%b", clu_rst_no, isolate_o, busy_o); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        clu_en = '0;
        vec++; if (dut_vec() !== RST_VEC) begin miss++;
            $display("FAIL rst_mid got=%h exp=%h", dut_vec(), RST_VEC); end
        repeat (8) begin
            step();
            vec++; if (dut_vec() !== exp_vec()) begin miss++;
                $display("FAIL rst_mid_after cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec()); end
        end
    endtask

`ifdef CHIMERA_CLU_PWR_IRQ_EN
    task automatic test_irq();
        delay[4] = 0;
        clu_en[4] = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            vec++; if (irq_o[4] !== 1'(k >= 14)) begin miss++;
                $display("FAIL irq_set k=%0d got=%b", k, irq_o[4]); end
        end
        irq_clr[4] = 1'b1;
        step();
        irq_clr[4] = 1'b0;
        vec++; if (irq_o[4] !== 1'b0) begin miss++;
            $display("FAIL irq_clr got=%b exp=0", irq_o[4]); end
        vec++; if (dut_vec() !== exp_vec()) begin miss++;
            $display("FAIL irq_model got=%h exp=%h", dut_vec(), exp_vec()); end
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 1500; n++) begin
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(15) == 0) clu_en[c] = ~clu_en[c];
                err_clr[c] = ($urandom_range(19) == 0);
`ifdef CHIMERA_CLU_PWR_IRQ_EN
                irq_clr[c] = ($urandom_range(7) == 0);
`endif
                if ($urandom_range(99) == 0) stuck[c] = int'($urandom_range(2));
                if ($urandom_range(49) == 0) delay[c] = int'($urandom_range(4));
            end
            rst = ($urandom_range(399) == 0);
            step();
            vec++; if (dut_vec() !== exp_vec()) begin miss++;
                $display("FAIL random cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec()); end
        end
        rst = 1'b0;
        err_clr = '0;
`ifdef CHIMERA_CLU_PWR_IRQ_EN
        irq_clr = '0;
`endif
    endtask

    initial begin
        rst      = 1'b1;
        clu_en   = '0;
        isolated = '1;
        err_clr  = '0;
`ifdef CHIMERA_CLU_PWR_IRQ_EN
        irq_clr  = '0;
        for (int c = 0; c < N; c++) m_irq[c] = 1'b0;
`endif
        for (int c = 0; c < N; c++) begin
            m_ph[c] = P_OFF; m_t[c] = 0; m_err[c] = 1'b0;
            delay[c] = 0; dcnt[c] = 0; stuck[c] = 0;
        end
        #2;
        test_reset();
        cyc = 0;
        test_power_up();
        test_power_down();
        test_iso_timeout();
        test_toggle();
        test_rst_mid();
`ifdef CHIMERA_CLU_PWR_IRQ_EN
        test_irq();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
